// File: rtl/wb_cmd_master.sv
// Wishbone classic initiator driven by a valid/ready command port.
// Runs one bus cycle per command and returns data or a timeout error.
module wb_cmd_master #(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int TIMEOUT = 255
) (
   input  logic            wb_clk_i,
   input  logic            wb_rst_i,
   input  logic            cmd_valid,
   output logic            cmd_ready,
   input  logic            cmd_we,
   input  logic [AW-1:0]   cmd_adr,
   input  logic [DW-1:0]   cmd_dat,
   input  logic [DW/8-1:0] cmd_sel,
   output logic            rsp_valid,
   input  logic            rsp_ready,
   output logic [DW-1:0]   rsp_dat,
   output logic            rsp_err,
   output logic            busy,
   output logic            wbm_cyc_o,
   output logic            wbm_stb_o,
   output logic            wbm_we_o,
   output logic [AW-1:0]   wbm_adr_o,
   output logic [DW-1:0]   wbm_dat_o,
   output logic [DW/8-1:0] wbm_sel_o,
   input  logic [DW-1:0]   wbm_dat_i,
   input  logic            wbm_ack_i
);

   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE,
      BUS,
      RESP
   } state_t;

   state_t        state;
   logic [CW-1:0] cnt;

   // Command FSM: every output is a register updated here
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state     <= IDLE;
         cnt       <= '0;
         cmd_ready <= 1'b1;
         rsp_valid <= 1'b0;
         rsp_dat   <= '0;
         rsp_err   <= 1'b0;
         busy      <= 1'b0;
         wbm_cyc_o <= 1'b0;
         wbm_stb_o <= 1'b0;
         wbm_we_o  <= 1'b0;
         wbm_adr_o <= '0;
         wbm_dat_o <= '0;
         wbm_sel_o <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (cmd_valid && cmd_ready) begin
                  wbm_we_o  <= cmd_we;
                  wbm_adr_o <= cmd_adr;
                  wbm_dat_o <= cmd_dat;
                  wbm_sel_o <= cmd_sel;
                  wbm_cyc_o <= 1'b1;
                  wbm_stb_o <= 1'b1;
                  cmd_ready <= 1'b0;
                  busy      <= 1'b1;
                  cnt       <= '0;
                  state     <= BUS;
               end
            end
            BUS: begin
               // ack wins over the timeout in the last permitted cycle
               if (wbm_ack_i) begin
                  wbm_cyc_o <= 1'b0;
                  wbm_stb_o <= 1'b0;
                  rsp_valid <= 1'b1;
                  rsp_dat   <= wbm_we_o ? '0 : wbm_dat_i;
                  rsp_err   <= 1'b0;
                  state     <= RESP;
               end else if (cnt == LAST) begin
                  wbm_cyc_o <= 1'b0;
                  wbm_stb_o <= 1'b0;
                  rsp_valid <= 1'b1;
                  rsp_dat   <= '0;
                  rsp_err   <= 1'b1;
                  state     <= RESP;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  rsp_dat   <= '0;
                  rsp_err   <= 1'b0;
                  cmd_ready <= 1'b1;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_wb_cmd_master.sv
// Directed bench for wb_cmd_master with a response scoreboard.
// TIMEOUT is shrunk to 4 so the abort path is reachable quickly.
module tb_wb_cmd_master;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 4;

   typedef struct {
      logic [DW-1:0] dat;
      logic          err;
   } rsp_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          cmd_valid;
   logic          cmd_ready;
   logic          cmd_we;
   logic [AW-1:0] cmd_adr;
   logic [DW-1:0] cmd_dat;
   logic [3:0]    cmd_sel;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [DW-1:0] rsp_dat;
   logic          rsp_err;
   logic          busy;
   logic          cyc;
   logic          stb;
   logic          we;
   logic [AW-1:0] adr;
   logic [DW-1:0] dat_o;
   logic [3:0]    sel;
   logic [DW-1:0] dat_i;
   logic          ack;

   int   n_pass  = 0;
   int   n_total = 0;
   rsp_t q[$];

   always #5 clk = ~clk;

   wb_cmd_master #(
      .AW(AW),
      .DW(DW),
      .TIMEOUT(TO)
   ) dut (
      .wb_clk_i (clk),
      .wb_rst_i (rst),
      .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready),
      .cmd_we   (cmd_we),
      .cmd_adr  (cmd_adr),
      .cmd_dat  (cmd_dat),
      .cmd_sel  (cmd_sel),
      .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready),
      .rsp_dat  (rsp_dat),
      .rsp_err  (rsp_err),
      .busy     (busy),
      .wbm_cyc_o(cyc),
      .wbm_stb_o(stb),
      .wbm_we_o (we),
      .wbm_adr_o(adr),
      .wbm_dat_o(dat_o),
      .wbm_sel_o(sel),
      .wbm_dat_i(dat_i),
      .wbm_ack_i(ack)
   );

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: got %0h, exp %0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // present a command, wait for acceptance, optionally record the response
   task automatic send(input logic w, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [3:0] s,
                       input bit push, input logic [DW-1:0] ed,
                       input logic ee);
      int n = 0;
      rsp_t e;
      cmd_we    = w;
      cmd_adr   = a;
      cmd_dat   = d;
      cmd_sel   = s;
      cmd_valid = 1'b1;
      if (push) begin
         e.dat = ed;
         e.err = ee;
         q.push_back(e);
      end
      while (cmd_ready !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      tick();
      cmd_valid = 1'b0;
      chk("accept_cyc", {63'd0, cyc}, 64'd1);
   endtask

   // act as slave: count stb cycles, ack in cycle ack_at (0 = never)
   task automatic run_bus(input int ack_at, input logic [DW-1:0] rd,
                          input logic w, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [3:0] s,
                          output int n);
      n = 0;
      while (stb === 1'b1 && n < 20) begin
         n++;
         chk("bus_hold", {cyc, we, sel, adr, dat_o[25:0]},
             {1'b1, w, s, a, d[25:0]});
         chk("bus_full_dat", {32'd0, dat_o}, {32'd0, d});
         chk("bus_flags", {62'd0, cmd_ready, busy}, 64'd1);
         if (n == ack_at) begin
            ack   = 1'b1;
            dat_i = rd;
         end
         tick();
         ack   = 1'b0;
         dat_i = $urandom;
      end
   endtask

   // wait for a response, score it, then complete the handshake
   task automatic take_rsp();
      int   n = 0;
      rsp_t e;
      while (rsp_valid !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      chk("rsp_valid", {63'd0, rsp_valid}, 64'd1);
      if (q.size() > 0) begin
         e = q.pop_front();
      end else begin
         e.dat = 'x;
         e.err = 1'bx;
      end
      chk("rsp_dat", {32'd0, rsp_dat}, {32'd0, e.dat});
      chk("rsp_err", {63'd0, rsp_err}, {63'd0, e.err});
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      chk("post_hs", {61'd0, rsp_valid, cmd_ready, busy}, 64'b010);
   endtask

   initial begin
      int            n;
      logic [DW-1:0] held;
      rst       = 1'b1;
      cmd_valid = 1'b0;
      cmd_we    = 1'b0;
      cmd_adr   = '0;
      cmd_dat   = '0;
      cmd_sel   = '0;
      rsp_ready = 1'b0;
      dat_i     = '0;
      ack       = 1'b0;
      #1;
      chk("rst_ready", {63'd0, cmd_ready}, 64'd1);
      chk("rst_outs", {cyc, stb, we, rsp_valid, rsp_err, busy, sel, adr},
          64'd0);
      chk("rst_data", {rsp_dat, dat_o}, 64'd0);
      tick();
      tick();
      rst = 1'b0;
      tick();

      // write, ack in third stb cycle
      send(1'b1, 32'h3000_0004, 32'hDEAD_BEEF, 4'hF, 1'b1, 32'h0, 1'b0);
      run_bus(3, 32'hFFFF_FFFF, 1'b1, 32'h3000_0004, 32'hDEAD_BEEF,
              4'hF, n);
      chk("wr_stb_len", 64'(n), 64'd3);
      chk("wr_cyc_drop", {62'd0, cyc, stb}, 64'd0);
      take_rsp();

      // read, immediate ack
      send(1'b0, 32'h3000_0000, 32'h0, 4'hF, 1'b1, 32'h1234_5678, 1'b0);
      run_bus(1, 32'h1234_5678, 1'b0, 32'h3000_0000, 32'h0, 4'hF, n);
      chk("rd_stb_len", 64'(n), 64'd1);
      chk("rd_latency", {63'd0, rsp_valid}, 64'd1);
      take_rsp();

      // timeout, slave never acks
      send(1'b0, 32'h3000_0010, 32'h0, 4'h3, 1'b1, 32'h0, 1'b1);
      run_bus(0, 32'h0, 1'b0, 32'h3000_0010, 32'h0, 4'h3, n);
      chk("to_stb_len", 64'(n), 64'(TO));
      take_rsp();

      // ack in the last permitted cycle beats the timeout
      send(1'b0, 32'h3000_0014, 32'h0, 4'h1, 1'b1, 32'hA5A5_0001, 1'b0);
      run_bus(TO, 32'hA5A5_0001, 1'b0, 32'h3000_0014, 32'h0, 4'h1, n);
      chk("late_ack_len", 64'(n), 64'(TO));
      take_rsp();

      // spurious ack while idle
      ack   = 1'b1;
      dat_i = 32'hBAD0_BAD0;
      repeat (3) tick();
      ack = 1'b0;
      chk("idle_ack", {60'd0, cyc, rsp_valid, cmd_ready, busy}, 64'b0010);
      chk("idle_ack_dat", {32'd0, rsp_dat}, 64'd0);

      // backpressure, with spurious ack and a pending command in RESP
      send(1'b0, 32'h3000_0020, 32'h0, 4'hF, 1'b1, 32'hCAFE_F00D, 1'b0);
      run_bus(2, 32'hCAFE_F00D, 1'b0, 32'h3000_0020, 32'h0, 4'hF, n);
      held      = rsp_dat;
      cmd_we    = 1'b1;
      cmd_adr   = 32'h3000_0024;
      cmd_dat   = 32'h0BAD_F00D;
      cmd_sel   = 4'h5;
      cmd_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         ack   = (i % 3) == 0;
         dat_i = $urandom;
         tick();
         chk("bp_hold", {30'd0, rsp_valid, cmd_ready, cyc, rsp_dat},
             {30'd0, 3'b100, held});
      end
      ack = 1'b0;
      chk("bp_dat", {32'd0, held}, 64'hCAFE_F00D);
      take_rsp();
      chk("no_accept_hs", {62'd0, cyc, cmd_ready}, 64'b01);
      tick();
      cmd_valid = 1'b0;
      chk("next_accept", {62'd0, cyc, cmd_ready}, 64'b10);
      q.push_back('{dat: 32'h0, err: 1'b0});
      run_bus(1, 32'h0, 1'b1, 32'h3000_0024, 32'h0BAD_F00D, 4'h5, n);
      chk("next_len", 64'(n), 64'd1);
      take_rsp();

      // reset during the second stb cycle
      send(1'b0, 32'h3000_0030, 32'h0, 4'hF, 1'b0, 32'h0, 1'b0);
      tick();
      chk("rst_pre_stb", {63'd0, stb}, 64'd1);
      #2;
      rst = 1'b1;
      #1;
      chk("rst_async", {60'd0, cyc, stb, rsp_valid, cmd_ready}, 64'b0001);
      tick();
      rst = 1'b0;
      tick();
      chk("rst_after", {61'd0, rsp_valid, busy, cmd_ready}, 64'b001);

      // read after reset completes normally
      send(1'b0, 32'h3000_0000, 32'h0, 4'hF, 1'b1, 32'h5555_AAAA, 1'b0);
      run_bus(1, 32'h5555_AAAA, 1'b0, 32'h3000_0000, 32'h0, 4'hF, n);
      chk("post_rst_len", 64'(n), 64'd1);
      take_rsp();
      chk("q_drained", 64'(q.size()), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
